// File: rtl/sys_clk_ctrl_if.sv
// sys_clk_ctrl_if: PLL lock input plus the reset/enable outputs of the clock controller
interface sys_clk_ctrl_if;
    logic       pll_lock;
    logic       sys_reset;
    logic       ce_32m;
    logic       ce_16m;
    logic       ce_8m;
    logic       running;
    logic [3:0] lock_loss_cnt;
    modport master (
        input  pll_lock,
        output sys_reset, ce_32m, ce_16m, ce_8m, running, lock_loss_cnt
    );
    modport slave (
        output pll_lock,
        input  sys_reset, ce_32m, ce_16m, ce_8m, running, lock_loss_cnt
    );
endinterface

// File: rtl/sys_clk_ctrl.sv
// sys_clk_ctrl: PLL lock qualification, system reset sequencing and 32/16/8 MHz enable generation
module sys_clk_ctrl #(
    parameter int LOCK_STABLE = 16384,
    parameter int RESET_HOLD  = 1024,
    parameter int CE_DIV      = 5
) (
    input logic clk,
    input logic reset,
    sys_clk_ctrl_if.master bus
);
    localparam int CW = $clog2(LOCK_STABLE > RESET_HOLD ? LOCK_STABLE : RESET_HOLD) + 1;
    localparam int DW = $clog2(CE_DIV);
    localparam logic [1:0] WAIT_LOCK = 2'd0, STABLE = 2'd1, HOLD = 2'd2, RUN = 2'd3;
    localparam logic [CW-1:0] LS_END = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] RH_END = CW'(RESET_HOLD - 1);
    localparam logic [DW-1:0] D_END = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] D_PRE = DW'(CE_DIV - 2);
    logic [1:0]    sync;
    logic          lock_s;
    logic [1:0]    state;
    logic [1:0]    nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic [1:0]    ph;
    logic          active;
    logic          fire;
    assign lock_s = sync[1];
    // loss of lock outranks both terminal counts
    assign nxt = (state == WAIT_LOCK) ? (lock_s ? STABLE : WAIT_LOCK) :
                 !lock_s ? WAIT_LOCK :
                 (state == STABLE && cnt == LS_END) ? HOLD :
                 (state == HOLD && cnt == RH_END) ? RUN : state;
    // enables only count while staying in HOLD/RUN, so HOLD entry restarts div/ph from zero
    assign active = (state == HOLD || state == RUN) && (nxt == HOLD || nxt == RUN);
    assign fire   = active && div == D_PRE;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync              <= '0;
            state             <= WAIT_LOCK;
            cnt               <= '0;
            div               <= '0;
            ph                <= '0;
            bus.sys_reset     <= 1'b1;
            bus.running       <= 1'b0;
            bus.ce_32m        <= 1'b0;
            bus.ce_16m        <= 1'b0;
            bus.ce_8m         <= 1'b0;
            bus.lock_loss_cnt <= '0;
        end else begin
            sync          <= {sync[0], bus.pll_lock};
            state         <= nxt;
            cnt           <= (nxt != state || state == WAIT_LOCK || state == RUN) ? '0 : cnt + 1'b1;
            div           <= active ? (div == D_END ? '0 : div + 1'b1) : '0;
            ph            <= active ? ph + {1'b0, bus.ce_32m} : '0;
            bus.ce_32m    <= fire;
            bus.ce_16m    <= fire && ph[0];
            bus.ce_8m     <= fire && ph == 2'd3;
            bus.sys_reset <= nxt != RUN;
            bus.running   <= nxt == RUN;
            if (state == RUN && !lock_s && bus.lock_loss_cnt != 4'hF)
                bus.lock_loss_cnt <= bus.lock_loss_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_sys_clk_ctrl.sv
// tb_sys_clk_ctrl: directed scoreboard bench for sys_clk_ctrl with LOCK_STABLE=8, RESET_HOLD=20, CE_DIV=5
module tb_sys_clk_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int fails = 0;
    typedef struct {
        string      tag;
        logic [8:0] val;
    } exp_t;
    exp_t q[$];
    sys_clk_ctrl_if bus();
    sys_clk_ctrl #(.LOCK_STABLE(8), .RESET_HOLD(20), .CE_DIV(5)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    // observed word: sys_reset, running, ce_32m, ce_16m, ce_8m, lock_loss_cnt
    function automatic logic [8:0] obs();
        return {bus.sys_reset, bus.running, bus.ce_32m, bus.ce_16m, bus.ce_8m, bus.lock_loss_cnt};
    endfunction
    // expected outputs e edges after the first edge sampling pll_lock=1 (HOLD begins after edge 11)
    function automatic logic [8:0] exp_at(int e, logic [3:0] c);
        logic rs, c32, c16, c8;
        rs  = e <= 30;
        c32 = e >= 15 && e % 5 == 0;
        c16 = e >= 20 && e % 10 == 0;
        c8  = e >= 30 && e % 20 == 10;
        return {rs, !rs, c32, c16, c8, c};
    endfunction
    task automatic push(string t, logic [8:0] v);
        q.push_back('{t, v});
    endtask
    task automatic go(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk();
        exp_t e;
        logic [8:0] o;
        total++;
        o = obs();
        if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty got %h", o);
        end else begin
            e = q.pop_front();
            assert (o === e.val) else begin
                fails++;
                $error("FAIL %s got %h want %h", e.tag, o, e.val);
            end
        end
    endtask
    initial begin
        logic [3:0] c;
        bus.pll_lock = 1'b1;
        go(3);
        push("reset_state", 9'h100);
        chk();
        reset = 1'b0;
        for (int e = 1; e <= 231; e++) push($sformatf("powerup_e%0d", e), exp_at(e, 4'd0));
        for (int e = 1; e <= 231; e++) begin
            go(1);
            chk();
        end
        for (int i = 1; i <= 17; i++) begin
            c = (i > 15) ? 4'd15 : 4'(i);
            bus.pll_lock = 1'b0;
            push($sformatf("loss%0d_e3", i), 9'h100 | {5'b0, c});
            go(3);
            chk();
            bus.pll_lock = 1'b1;
            push($sformatf("relock%0d_e30", i), exp_at(30, c));
            push($sformatf("relock%0d_e31", i), exp_at(31, c));
            go(30);
            chk();
            go(1);
            chk();
        end
        reset = 1'b1;
        push("midrun_reset", 9'h100);
        go(1);
        chk();
        reset = 1'b0;
        push("reseq_e30", exp_at(30, 4'd0));
        push("reseq_e31", exp_at(31, 4'd0));
        go(30);
        chk();
        go(1);
        chk();
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        go(4);
        bus.pll_lock = 1'b0;
        go(3);
        bus.pll_lock = 1'b1;
        push("unstable_e14", exp_at(14, 4'd0));
        push("unstable_e15", exp_at(15, 4'd0));
        push("unstable_e30", exp_at(30, 4'd0));
        push("unstable_e31", exp_at(31, 4'd0));
        go(14);
        chk();
        go(1);
        chk();
        go(15);
        chk();
        go(1);
        chk();
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        go(8);
        bus.pll_lock = 1'b0;
        go(2);
        bus.pll_lock = 1'b1;
        push("simul_no_hold", 9'h100);
        push("simul_relock_e30", exp_at(30, 4'd0));
        push("simul_relock_e31", exp_at(31, 4'd0));
        go(5);
        chk();
        go(25);
        chk();
        go(1);
        chk();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
